// File: rtl/ser_pkg.sv
// Shared types and constants for the word serializer.
// Optional macro SER_GAP_EN adds a one-cycle GAP state after each word.
package ser_pkg;

  localparam int SER_WIDTH_DEF = 8;

`ifdef SER_GAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;
`endif

  // Bit-counter width for a word of w bits.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ser_shreg.sv
// Shift register plus bit counter for the word serializer.
// Unaffected by SER_GAP_EN; the FSM in word_serializer drives it.
module ser_shreg
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clr_cnt,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_bit0,
  output logic             o_last
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;

  // Load wins over shift so a back-to-back word is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_din;
    end else if (i_shift) begin
      r_sr <= {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  // Counter saturates at WIDTH-1 until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_cnt <= '0;
    end else if (i_shift && !o_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit0 = r_sr[0];
  assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial word serializer, LSB first, with per-word clear.
// Define SER_GAP_EN to insert one GAP cycle after every word.
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_bit,
  output logic             ser_clr,
  output logic             ser_active,
  output logic             done
);

  state_t r_state;
  state_t w_nxt;
  logic   w_load;
  logic   w_shift;
  logic   w_clr_cnt;
  logic   w_bit0;
  logic   w_last;

  ser_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk      (t_clk),
    .rst      (r),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_clr_cnt(w_clr_cnt),
    .i_din    (din),
    .o_bit0   (w_bit0),
    .o_last   (w_last)
  );

  // State register.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next state and state-decoded controls.
  always_comb begin
    w_nxt      = r_state;
    din_ready  = 1'b0;
    ser_clr    = 1'b1;
    ser_active = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_clr_cnt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          w_load = 1'b1;
          w_nxt  = CLR;
        end
      end
      CLR: begin
        w_clr_cnt = 1'b1;
        w_nxt     = SHIFT;
      end
      SHIFT: begin
        ser_clr    = 1'b0;
        ser_active = 1'b1;
        w_shift    = 1'b1;
        if (w_last) begin
`ifdef SER_GAP_EN
          w_nxt = GAP;
`else
          din_ready = 1'b1;
          if (din_valid) begin
            w_load = 1'b1;
            w_nxt  = CLR;
          end else begin
            w_nxt = IDLE;
          end
`endif
        end
      end
`ifdef SER_GAP_EN
      GAP: begin
        w_nxt = IDLE;
      end
`endif
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  assign ser_bit = ser_active & w_bit0;
  assign done    = (r_state == SHIFT) && w_last;

endmodule
